// File: rtl/fp_mul_iter_if.sv
// fp_mul_iter_if: handshake bundle for the iterative FP multiplier.
//   in_valid/in_ready   : operand handshake (fp_X, fp_Y, r_mode)
//   out_valid/out_ready : result handshake (fp_Z plus ovrf/udrf/zer/inf/nan/nx)
// master = producer of operands / consumer of results, slave = the multiplier.
interface fp_mul_iter_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] fp_X;
  logic [W-1:0] fp_Y;
  logic [2:0]   r_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] fp_Z;
  logic         ovrf;
  logic         udrf;
  logic         zer;
  logic         inf;
  logic         nan;
  logic         nx;

  modport master (
    output in_valid, fp_X, fp_Y, r_mode, out_ready,
    input  in_ready, out_valid, fp_Z, ovrf, udrf, zer, inf, nan, nx
  );

  modport slave (
    input  in_valid, fp_X, fp_Y, r_mode, out_ready,
    output in_ready, out_valid, fp_Z, ovrf, udrf, zer, inf, nan, nx
  );
endinterface

// File: rtl/fp_mul_iter.sv
// fp_mul_iter: multi-cycle IEEE-754 multiplier with flush-to-zero.
// The significand product is built by a radix-4 Booth accumulator, one digit
// per cycle, followed by a single normalise/round/exception cycle.
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active-high
//   bus  : fp_mul_iter_if.slave (operand and result valid/ready handshakes,
//          operands fp_X/fp_Y, rounding mode r_mode, result fp_Z and flags)
module fp_mul_iter #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic          clk,
  input  logic          rst,
  fp_mul_iter_if.slave  bus
);
  localparam int W      = 1 + EXP_W + FRAC_W;
  localparam int M      = FRAC_W + 1;
  localparam int N_ITER = (M + 2) / 2;
  localparam int PW     = 2 * M;
  localparam int YW     = 2 * N_ITER + 1;
  localparam int IW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam int EW     = EXP_W + 2;
  localparam int BIAS   = 2 ** (EXP_W - 1) - 1;

  localparam logic [IW-1:0]        LAST_ITER = IW'(N_ITER - 1);
  localparam logic signed [EW-1:0] E_OVF     = EW'(2 ** EXP_W - 1);
  localparam logic signed [EW-1:0] E_ZERO    = '0;

  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RND,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0]    iter;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [YW-1:0]    y_sh;
  logic             sgn;
  logic [EXP_W-1:0] ex_q, ey_q;
  logic [2:0]       mode_q;
  logic             x_zero_q, x_inf_q, x_nan_q;
  logic             y_zero_q, y_inf_q, y_nan_q;

  logic [W-1:0]     z_q;
  logic             ovrf_q, udrf_q, zer_q, inf_q, nan_q, nx_q;

  // Operand unpack, straight from the bus so it can be captured on accept.
  logic [EXP_W-1:0]  ex_in, ey_in;
  logic [FRAC_W-1:0] fx_in, fy_in;
  logic              x_zero_in, x_inf_in, x_nan_in;
  logic              y_zero_in, y_inf_in, y_nan_in;

  assign ex_in     = bus.fp_X[W-2 -: EXP_W];
  assign ey_in     = bus.fp_Y[W-2 -: EXP_W];
  assign fx_in     = bus.fp_X[FRAC_W-1:0];
  assign fy_in     = bus.fp_Y[FRAC_W-1:0];
  assign x_zero_in = (ex_in == '0);
  assign y_zero_in = (ey_in == '0);
  assign x_inf_in  = (&ex_in) && (fx_in == '0);
  assign y_inf_in  = (&ey_in) && (fy_in == '0);
  assign x_nan_in  = (&ex_in) && (fx_in != '0);
  assign y_nan_in  = (&ey_in) && (fy_in != '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = MUL;
      MUL:     if (iter == LAST_ITER) state_nxt = RND;
      RND:     state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Booth digit from the low three bits of the shifted multiplier. The
  // accumulator works modulo 2^PW: partial sums may wrap negative, but the
  // final product is non-negative and fits, so the wrap cancels out.
  logic [PW-1:0] pp;
  always_comb begin
    pp = '0;
    case (y_sh[2:0])
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = {mcand[PW-2:0], 1'b0};
      3'b100:         pp = -{mcand[PW-2:0], 1'b0};
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
  end

  // Normalise, round, exponent and special-value resolution.
  logic [PW-1:0]          p_n;
  logic                   norm_n, guard, sticky, inc, carry;
  logic [M-1:0]           mant;
  logic [M:0]             mant_r;
  logic [FRAC_W-1:0]      frac_r;
  logic signed [EW-1:0]   e_sum;
  logic [W-1:0]           z_nxt;
  logic                   ovrf_nxt, udrf_nxt, zer_nxt, inf_nxt, nan_nxt, nx_nxt;
  logic [W-1:0]           inf_val, max_val;

  always_comb begin
    norm_n = acc[PW-1];
    p_n    = norm_n ? acc : {acc[PW-2:0], 1'b0};
    mant   = p_n[PW-1:M];
    guard  = p_n[M-1];
    sticky = |p_n[M-2:0];

    case (mode_q)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sgn & (guard | sticky);
      RM_RUP:  inc = ~sgn & (guard | sticky);
      RM_RMM:  inc = guard;
      default: inc = guard & (sticky | mant[0]);
    endcase

    mant_r = {1'b0, mant} + {{M{1'b0}}, inc};
    carry  = mant_r[M];
    frac_r = carry ? mant_r[M-1:1] : mant_r[FRAC_W-1:0];
    e_sum  = EW'(ex_q) + EW'(ey_q) - EW'(BIAS) + EW'(norm_n) + EW'(carry);

    inf_val = {sgn, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    max_val = {sgn, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};

    z_nxt    = {sgn, e_sum[EXP_W-1:0], frac_r};
    ovrf_nxt = 1'b0;
    udrf_nxt = 1'b0;
    zer_nxt  = 1'b0;
    inf_nxt  = 1'b0;
    nan_nxt  = 1'b0;
    nx_nxt   = guard | sticky;

    if (x_nan_q || y_nan_q || (x_inf_q && y_zero_q) || (y_inf_q && x_zero_q)) begin
      z_nxt   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
      nan_nxt = 1'b1;
      nx_nxt  = 1'b0;
    end else if (x_inf_q || y_inf_q) begin
      z_nxt   = inf_val;
      inf_nxt = 1'b1;
      nx_nxt  = 1'b0;
    end else if (x_zero_q || y_zero_q) begin
      z_nxt   = {sgn, {(W-1){1'b0}}};
      zer_nxt = 1'b1;
      nx_nxt  = 1'b0;
    end else if (e_sum >= E_OVF) begin
      ovrf_nxt = 1'b1;
      nx_nxt   = 1'b1;
      // Directed modes saturate to max finite when rounding toward zero.
      case (mode_q)
        RM_RTZ:  z_nxt = max_val;
        RM_RDN:  z_nxt = sgn ? inf_val : max_val;
        RM_RUP:  z_nxt = sgn ? max_val : inf_val;
        default: z_nxt = inf_val;
      endcase
      inf_nxt = (z_nxt == inf_val);
    end else if (e_sum <= E_ZERO) begin
      z_nxt    = {sgn, {(W-1){1'b0}}};
      udrf_nxt = 1'b1;
      zer_nxt  = 1'b1;
      nx_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iter     <= '0;
      acc      <= '0;
      mcand    <= '0;
      y_sh     <= '0;
      sgn      <= 1'b0;
      ex_q     <= '0;
      ey_q     <= '0;
      mode_q   <= '0;
      x_zero_q <= 1'b0;
      x_inf_q  <= 1'b0;
      x_nan_q  <= 1'b0;
      y_zero_q <= 1'b0;
      y_inf_q  <= 1'b0;
      y_nan_q  <= 1'b0;
      z_q      <= '0;
      ovrf_q   <= 1'b0;
      udrf_q   <= 1'b0;
      zer_q    <= 1'b0;
      inf_q    <= 1'b0;
      nan_q    <= 1'b0;
      nx_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            iter     <= '0;
            acc      <= '0;
            mcand    <= {{(PW-M){1'b0}}, 1'b1, fx_in};
            // Trailing zero is the implicit y[-1] of the Booth recoding.
            y_sh     <= {{(YW-M-1){1'b0}}, 1'b1, fy_in, 1'b0};
            sgn      <= bus.fp_X[W-1] ^ bus.fp_Y[W-1];
            ex_q     <= ex_in;
            ey_q     <= ey_in;
            mode_q   <= bus.r_mode;
            x_zero_q <= x_zero_in;
            x_inf_q  <= x_inf_in;
            x_nan_q  <= x_nan_in;
            y_zero_q <= y_zero_in;
            y_inf_q  <= y_inf_in;
            y_nan_q  <= y_nan_in;
          end
        end
        MUL: begin
          acc   <= acc + pp;
          mcand <= {mcand[PW-3:0], 2'b00};
          y_sh  <= {2'b00, y_sh[YW-1:2]};
          iter  <= iter + 1'b1;
        end
        RND: begin
          z_q    <= z_nxt;
          ovrf_q <= ovrf_nxt;
          udrf_q <= udrf_nxt;
          zer_q  <= zer_nxt;
          inf_q  <= inf_nxt;
          nan_q  <= nan_nxt;
          nx_q   <= nx_nxt;
        end
        default: ;
      endcase
    end
  end

  // Flags are only meaningful with out_valid, so they read as zero otherwise.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.fp_Z      = z_q;
  assign bus.ovrf      = ovrf_q & (state == DONE);
  assign bus.udrf      = udrf_q & (state == DONE);
  assign bus.zer       = zer_q  & (state == DONE);
  assign bus.inf       = inf_q  & (state == DONE);
  assign bus.nan       = nan_q  & (state == DONE);
  assign bus.nx        = nx_q   & (state == DONE);
endmodule

// File: tb/tb_fp_mul_iter.sv
// tb_fp_mul_iter: self-checking bench for fp_mul_iter (FP32 configuration).
// Table of vectors with hand-computed results, a scoreboard queue, and
// directed sequences for backpressure and mid-operation reset.
module tb_fp_mul_iter;
  localparam logic [2:0] RNE = 3'b000;
  localparam logic [2:0] RTZ = 3'b001;
  localparam logic [2:0] RDN = 3'b010;
  localparam logic [2:0] RUP = 3'b011;
  localparam logic [2:0] RMM = 3'b100;

  // Flag vector order: {ovrf, udrf, zer, inf, nan, nx}
  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_OVRF = 6'b100000;
  localparam logic [5:0] F_UDRF = 6'b010000;
  localparam logic [5:0] F_ZER  = 6'b001000;
  localparam logic [5:0] F_INF  = 6'b000100;
  localparam logic [5:0] F_NAN  = 6'b000010;
  localparam logic [5:0] F_NX   = 6'b000001;

  localparam int LATENCY = 14;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  mode;
    logic [31:0] z;
    logic [5:0]  f;
  } vec_t;

  typedef struct {
    logic [31:0] z;
    logic [5:0]  f;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_mul_iter_if #(.W(32)) bus ();

  fp_mul_iter #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle_cnt = 0;
  int   accept_cycle = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  function automatic logic [5:0] flagsNow();
    return {bus.ovrf, bus.udrf, bus.zer, bus.inf, bus.nan, bus.nx};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic addVec(input logic [31:0] x, input logic [31:0] y, input logic [2:0] mode,
                        input logic [31:0] z, input logic [5:0] f);
    vec_t v;
    v.x = x; v.y = y; v.mode = mode; v.z = z; v.f = f;
    vecs.push_back(v);
  endtask

  // Waits for in_ready, presents one operand pair for exactly one accept edge.
  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic [2:0] mode,
                               input logic [31:0] ez, input logic [5:0] ef, input bit push);
    int   waited = 0;
    exp_t e;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.fp_X     = x;
    bus.fp_Y     = y;
    bus.r_mode   = mode;
    bus.in_valid = 1'b1;
    if (push) begin
      e.z = ez;
      e.f = ef;
      sb_q.push_back(e);
    end
    @(negedge clk);
    accept_cycle = cycle_cnt;
    bus.in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid, checks latency and pops the scoreboard.
  task automatic checkOutput(input string tag);
    int   waited = 0;
    exp_t e;
    while (!bus.out_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_latency"}, 32'(cycle_cnt - accept_cycle), 32'(LATENCY));
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_scoreboard: got empty queue expected entry", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_fp_Z"}, bus.fp_Z, e.z);
      check({tag, "_flags"}, 32'(flagsNow()), 32'(e.f));
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.fp_X      = '0;
    bus.fp_Y      = '0;
    bus.r_mode    = RNE;

    addVec(32'h40400000, 32'h40400000, RTZ, 32'h41100000, F_NONE);
    addVec(32'h80400000, 32'h3F800000, RNE, 32'h80000000, F_ZER);
    addVec(32'h20000000, 32'h1F800000, RTZ, 32'h00000000, F_UDRF | F_ZER | F_NX);
    addVec(32'h7F800000, 32'h00000000, RNE, 32'h7FC00000, F_NAN);
    addVec(32'hFF800000, 32'h40000000, RNE, 32'hFF800000, F_INF);
    addVec(32'h7F000000, 32'h40000000, RNE, 32'h7F800000, F_OVRF | F_INF | F_NX);
    addVec(32'h7F000000, 32'h40000000, RTZ, 32'h7F7FFFFF, F_OVRF | F_NX);
    addVec(32'h7F000000, 32'h40000000, RUP, 32'h7F800000, F_OVRF | F_INF | F_NX);
    addVec(32'h7F000000, 32'h40000000, RDN, 32'h7F7FFFFF, F_OVRF | F_NX);
    addVec(32'hFF000000, 32'h40000000, RDN, 32'hFF800000, F_OVRF | F_INF | F_NX);
    addVec(32'hFF000000, 32'h40000000, RUP, 32'hFF7FFFFF, F_OVRF | F_NX);
    addVec(32'h3F800001, 32'h3F800001, RNE, 32'h3F800002, F_NX);
    addVec(32'h3F800001, 32'h3F800001, RTZ, 32'h3F800002, F_NX);
    addVec(32'h3F800001, 32'h3F800001, RUP, 32'h3F800003, F_NX);
    addVec(32'hBF800001, 32'h3F800001, RDN, 32'hBF800003, F_NX);
    addVec(32'h3F800003, 32'h3FC00000, RNE, 32'h3FC00004, F_NX);
    addVec(32'h3F800003, 32'h3FC00000, RMM, 32'h3FC00005, F_NX);
    addVec(32'h3F800003, 32'h3FC00000, 3'b111, 32'h3FC00004, F_NX);
    addVec(32'hFFA00000, 32'h3F800000, RNE, 32'h7FC00000, F_NAN);
    addVec(32'h00000000, 32'hFF800000, RNE, 32'h7FC00000, F_NAN);
    addVec(32'h80000000, 32'h40000000, RNE, 32'h80000000, F_ZER);
    addVec(32'hC0000000, 32'h40400000, RNE, 32'hC0C00000, F_NONE);

    repeat (3) @(negedge clk);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_fp_Z", bus.fp_Z, 32'h0);
    check("reset_flags", 32'(flagsNow()), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].x, vecs[i].y, vecs[i].mode, vecs[i].z, vecs[i].f, 1'b1);
      checkOutput($sformatf("vec%0d", i));
      @(negedge clk);
      check($sformatf("vec%0d_flags_idle", i), 32'(flagsNow()), 32'd0);
      check($sformatf("vec%0d_valid_idle", i), 32'(bus.out_valid), 32'd0);
    end

    // Backpressure: result held in DONE while a competing request is ignored.
    bus.out_ready = 1'b0;
    applyStimulus(32'h40400000, 32'h40400000, RTZ, 32'h41100000, F_NONE, 1'b1);
    checkOutput("bp");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.fp_X     = 32'h3F800000;
      bus.fp_Y     = 32'h3F800000;
      bus.r_mode   = RNE;
      bus.in_valid = 1'b1;
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_fp_Z", bus.fp_Z, 32'h41100000);
      check("bp_hold_flags", 32'(flagsNow()), 32'd0);
      check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("bp_no_spurious_result", 32'(seen), 32'd0);

    // Reset in the middle of the Booth iterations aborts the operation.
    applyStimulus(32'h3F800001, 32'h3F800001, RNE, 32'h0, F_NONE, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_mid_fp_Z", bus.fp_Z, 32'h0);
    check("rst_mid_flags", 32'(flagsNow()), 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("rst_mid_no_result", 32'(seen), 32'd0);

    applyStimulus(32'hC0000000, 32'h40400000, RNE, 32'hC0C00000, F_NONE, 1'b1);
    checkOutput("recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
